mem_loader: RTL and testbench

Byte-stream memory loader that fills instruction and data memory of `Main` before execution, the write-side counterpart of the bench memory dump. Sits between a byte source (UART receiver or bench driver) and the write ports of the instruction and data memories. It holds the CPU in reset while a frame is in progress.

---
 rtl/loader_pkg.sv | 8 +
 rtl/mem_loader_word_assembler.sv | 21 ++
 rtl/mem_loader.sv | 99 +++++++++
 tb/tb_mem_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding, frame target codes and default memory depths for mem_loader
package loader_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_COUNT, S_DATA, S_WRITE, S_CKSUM, S_DONE} state_t;
    localparam logic [7:0] TARGET_I = 8'h49;
    localparam logic [7:0] TARGET_D = 8'h44;
    localparam int IMEM_WORDS_DEF = 64;
    localparam int DMEM_WORDS_DEF = 256;
endpackage

// File: rtl/mem_loader_word_assembler.sv
// word_assembler: packs four bytes little-endian into a word, flags the cycle the last byte arrives
module word_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [31:0] word,
    output logic        word_valid
);
    logic [1:0] bcnt;
    always_ff @(posedge clock) begin
        if (reset) begin
            bcnt <= 2'd0;
            word <= 32'd0;
        end else if (byte_valid) begin
            word[{bcnt, 3'b000} +: 8] <= byte_in;
            bcnt <= bcnt + 2'd1;
        end
    end
    assign word_valid = byte_valid && bcnt == 2'd3;
endmodule

// File: rtl/mem_loader.sv
// mem_loader: byte-stream frame loader for instruction/data memory; MEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
module mem_loader
    import loader_pkg::*;
#(
    parameter int IMEM_WORDS = IMEM_WORDS_DEF,
    parameter int DMEM_WORDS = DMEM_WORDS_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic        dmem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);
    state_t      state, state_n;
    logic        hs, is_target, target_d, word_valid;
    logic [31:0] index, word, idx_mask;
    logic [7:0]  count;

    assign rx_ready  = !reset && state != S_WRITE && state != S_DONE;
    assign hs        = rx_valid && rx_ready;
    assign is_target = rx_data == TARGET_I || rx_data == TARGET_D;

    word_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .byte_in    (rx_data),
        .byte_valid (hs && state == S_DATA),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clock) state <= reset ? S_IDLE : state_n;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = hs && is_target ? S_ADDR : S_IDLE;
            S_ADDR:  state_n = hs ? S_COUNT : S_ADDR;
            S_COUNT: state_n = hs ? S_DATA : S_COUNT;
            S_DATA:  state_n = word_valid ? S_WRITE : S_DATA;
`ifdef MEM_LOADER_CHECKSUM_EN
            S_WRITE: state_n = count != 8'd0 ? S_DATA : S_CKSUM;
`else
            S_WRITE: state_n = count != 8'd0 ? S_DATA : S_DONE;
`endif
            S_CKSUM: state_n = hs ? S_DONE : S_CKSUM;
            default: state_n = S_IDLE;
        endcase
    end

    // index wraps inside the selected memory, so mask rather than compare
    assign idx_mask  = target_d ? 32'(DMEM_WORDS - 1) : 32'(IMEM_WORDS - 1);
    assign imem_we   = state == S_WRITE && !target_d;
    assign dmem_we   = state == S_WRITE && target_d;
    assign mem_addr  = state == S_WRITE ? (index & idx_mask) << 2 : 32'd0;
    assign mem_wdata = state == S_WRITE ? word : 32'd0;
    assign cpu_hold  = state != S_IDLE;
    assign done      = state == S_DONE;

`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    always_ff @(posedge clock) begin
        if (reset || (state == S_IDLE && hs))
            csum <= 8'd0;
        else if (hs && (state == S_ADDR || state == S_COUNT || state == S_DATA))
            csum <= csum ^ rx_data;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            target_d <= 1'b0;
            index    <= 32'd0;
            count    <= 8'd0;
            err      <= 1'b0;
        end else begin
            if (state == S_IDLE && hs) begin
                err <= !is_target;
                if (is_target) target_d <= rx_data == TARGET_D;
            end
            if (state == S_ADDR && hs) index <= {24'd0, rx_data};
            if (state == S_COUNT && hs) count <= rx_data;
            if (state == S_WRITE) begin
                index <= index + 32'd1;
                count <= count - 8'd1;
            end
`ifdef MEM_LOADER_CHECKSUM_EN
            if (state == S_CKSUM && hs && rx_data != csum) err <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed frames against mem_loader, writes captured just after each rising edge
module tb_mem_loader;
`ifdef MEM_LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    logic        clock, reset, rx_valid, rx_ready;
    logic [7:0]  rx_data;
    logic        imem_we, dmem_we, cpu_hold, done, err;
    logic [31:0] mem_addr, mem_wdata;

    mem_loader dut (
        .clock     (clock),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .imem_we   (imem_we),
        .dmem_we   (dmem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          total = 0, bad = 0, cyc = 0, hs_cyc = 0, c0 = 0;
    int          ndone = 0, done_cyc = 0, rise_cyc = 0, fall_cyc = 0;
    logic        hold_q = 1'b0;
    logic [7:0]  tb_x = 8'd0;
    logic [31:0] wa[$], wd[$];
    logic        wi[$], wdm[$];
    int          wc[$];

    always @(posedge clock) begin
        cyc++;
        #1;
        if (imem_we || dmem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wi.push_back(imem_we);
            wdm.push_back(dmem_we);
            wc.push_back(cyc);
        end
        if (done) begin
            ndone++;
            done_cyc = cyc;
        end
        if (cpu_hold && !hold_q) rise_cyc = cyc;
        if (!cpu_hold && hold_q) fall_cyc = cyc;
        hold_q = cpu_hold;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        wa.delete(); wd.delete(); wi.delete(); wdm.delete(); wc.delete();
        ndone = 0;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("handshake_timeout", 32'(n < 50), 32'd1);
        hs_cyc = cyc;
        tb_x ^= b;
        @(negedge clock);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
    endtask

    task automatic start_frame(input logic [7:0] t, input logic [7:0] s, input logic [7:0] c);
        send(t);
        c0   = hs_cyc;
        tb_x = 8'd0;
        send(s);
        send(c);
    endtask

    task automatic wait_done();
        int n = 0;
        rx_valid = 1'b0;
        while (!done && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
        @(negedge clock);
    endtask

    task automatic end_frame();
`ifdef MEM_LOADER_CHECKSUM_EN
        send(tb_x);
`endif
        wait_done();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"}, 32'(rx_ready), 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_we"}, 32'({imem_we, dmem_we}), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'd0;
        repeat (3) @(negedge clock);
        chk_quiet("rst");
        reset = 1'b0;
        #1;
        chk("rst_ready_after", 32'(rx_ready), 32'd1);
        @(negedge clock);

        // two-word data frame
        clr();
        start_frame(8'h44, 8'h05, 8'h01);
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        end_frame();
        chk("d_nwr", wa.size(), 32'd2);
        chk("d_a0", wa[0], 32'h14);
        chk("d_w0", wd[0], 32'h12345678);
        chk("d_a1", wa[1], 32'h18);
        chk("d_w1", wd[1], 32'hDEADBEEF);
        chk("d_dmem", 32'({wdm[0], wdm[1], wi[0], wi[1]}), 32'b1100);
        chk("d_wr0_cyc", wc[0] - c0, 32'd7);
        chk("d_wr1_cyc", wc[1] - c0, 32'd12);
        chk("d_ndone", ndone, 32'd1);
        chk("d_done_cyc", done_cyc - c0, 32'(13 + CK));
        chk("d_hold_rise", rise_cyc - c0, 32'd1);
        chk("d_hold_fall", fall_cyc - c0, 32'(14 + CK));
        chk("d_err", 32'(err), 32'd0);

        // instruction frame wrapping at 64 words
        clr();
        start_frame(8'h49, 8'h3F, 8'h01);
        send_word(32'h11223344);
        send_word(32'h55667788);
        end_frame();
        chk("i_nwr", wa.size(), 32'd2);
        chk("i_a0", wa[0], 32'hFC);
        chk("i_a1", wa[1], 32'h0);
        chk("i_w1", wd[1], 32'h55667788);
        chk("i_flags", 32'({wi[0], wi[1], wdm[0], wdm[1]}), 32'b1100);

        // bad target byte, then a good frame clears err
        clr();
        send(8'h00);
        rx_valid = 1'b0;
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_hold", 32'(cpu_hold), 32'd0);
        repeat (3) @(negedge clock);
        chk("bad_nwr", wa.size(), 32'd0);
        start_frame(8'h44, 8'h10, 8'h00);
        chk("bad_cleared", 32'(err), 32'd0);
        send_word(32'hAABBCCDD);
        end_frame();
        chk("bad_a0", wa[0], 32'h40);
        chk("bad_w0", wd[0], 32'hAABBCCDD);

        // 7-cycle stall between data bytes 2 and 3
        clr();
        start_frame(8'h44, 8'h02, 8'h00);
        send(8'h01);
        send(8'h02);
        rx_valid = 1'b0;
        repeat (7) @(negedge clock);
        send(8'h03);
        send(8'h04);
        end_frame();
        chk("stall_nwr", wa.size(), 32'd1);
        chk("stall_a0", wa[0], 32'h8);
        chk("stall_w0", wd[0], 32'h04030201);
        chk("stall_cyc", wc[0] - c0, 32'd14);

        // reset after two data bytes, then a fresh frame
        clr();
        start_frame(8'h44, 8'h07, 8'h00);
        send(8'hAA);
        send(8'hBB);
        rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk_quiet("midrst");
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("midrst_nwr", wa.size(), 32'd0);
        chk("midrst_ndone", ndone, 32'd0);
        start_frame(8'h44, 8'h07, 8'h00);
        send_word(32'h44332211);
        end_frame();
        chk("fresh_nwr", wa.size(), 32'd1);
        chk("fresh_a0", wa[0], 32'h1C);
        chk("fresh_w0", wd[0], 32'h44332211);
        chk("fresh_ndone", ndone, 32'd1);

`ifdef MEM_LOADER_CHECKSUM_EN
        clr();
        start_frame(8'h44, 8'h00, 8'h00);
        send_word(32'h04030201);
        send(8'h04);
        wait_done();
        chk("ck_good_err", 32'(err), 32'd0);
        chk("ck_good_done", ndone, 32'd1);
        clr();
        start_frame(8'h44, 8'h00, 8'h00);
        send_word(32'h04030201);
        send(8'h05);
        wait_done();
        chk("ck_bad_err", 32'(err), 32'd1);
        chk("ck_bad_done", ndone, 32'd1);
        chk("ck_bad_nwr", wa.size(), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
